// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-facing arbitration blocks.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 16;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 1'b0;
  localparam arb_state_t ST_LOCKED = 1'b1;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module rr_priority_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0]   sum;
  logic [IW-1:0] sel;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    sel    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      sel = sum[IW-1:0];
      if (!any && req[sel]) begin
        any         = 1'b1;
        onehot[sel] = 1'b1;
        idx         = sel;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with burst locking in front of a single-ported SRAM.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      sram_write_enable,
  output logic [ADDR_W-1:0]         sram_write_addresss,
  output logic [DATA_W-1:0]         sram_write_data,
  output logic [ADDR_W-1:0]         sram_read_address,
  input  logic [DATA_W-1:0]         sram_read_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam bit LOCKABLE = (MAX_BURST > 1);

  arb_state_t                       state;
  logic [IW-1:0]                    rr_ptr, owner, pick_idx, win_idx;
  logic [CW-1:0]                    burst_cnt, burst_inc;
  logic [NUM_REQ-1:0]               pick_oh, gnt_raw;
  logic                             pick_any, last_beat;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wdata_v;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign rdata   = sram_read_data;

  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // While locked, the owner alone may use the port; others wait even if it idles.
  always_comb begin
    gnt_raw = pick_oh;
    win_idx = pick_idx;
    if (state == ST_LOCKED) begin
      gnt_raw        = '0;
      gnt_raw[owner] = req[owner];
      win_idx        = owner;
    end
  end

  assign gnt = reset ? '0 : gnt_raw;

  always_comb begin
    sram_write_enable   = 1'b0;
    sram_write_addresss = '0;
    sram_read_address   = '0;
    sram_write_data     = '0;
    if (|gnt) begin
      sram_write_enable   = req_we[win_idx];
      sram_write_addresss = addr_v[win_idx];
      sram_read_address   = addr_v[win_idx];
      sram_write_data     = wdata_v[win_idx];
    end
  end

  assign burst_inc = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
  assign last_beat = (burst_cnt >= CW'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rvalid    <= '0;
    end else begin
      rvalid <= gnt & ~req_we;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (LOCKABLE && req_lock[pick_idx]) begin
              state     <= ST_LOCKED;
              owner     <= pick_idx;
              burst_cnt <= CW'(1);
            end
          end
        end
        default: begin
          // rr_ptr already points past the owner, so any release hands over fairly.
          if (req[owner]) begin
            burst_cnt <= burst_inc;
            if (!req_lock[owner] || last_beat) state <= ST_IDLE;
          end else if (!req_lock[owner]) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported 16-bit SRAM interface (input, weights, scratchpad or output SRAM) between NUM_REQ requesters, for example the convolution controller, a host/testbench loader and a debug reader.
- Arbitration is round-robin with optional burst locking, so the convolution engine's multi-cycle read sequences (kernel fetch, 3x3 window fetch) are not interleaved.
- Returns a per-requester read-valid strobe aligned to the SRAM's 1-cycle read latency.
- Sits between the requesters and the SRAM macro ports.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 12, SRAM address width
- DATA_W, 16, SRAM data width
- MAX_BURST, 16, maximum consecutive grants to one locked requester before a forced release

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester access request
- req_lock  in  NUM_REQ  per-requester: keep ownership after this access
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_REQ  one-hot, registered: sram_read_data is valid for that requester this cycle
- rdata  out  DATA_W  sram_read_data passed straight through
- sram_write_enable  out  1  to SRAM
- sram_write_addresss  out  ADDR_W  to SRAM
- sram_write_data  out  DATA_W  to SRAM
- sram_read_address  out  ADDR_W  to SRAM
- sram_read_data  in  DATA_W  from SRAM, valid 1 cycle after read address

Behaviour:
- Reset (async, high): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, rvalid=0. While no grant, outputs are sram_write_enable=0, addresses=0, write data=0.
- States:
  - IDLE: no owner; arbitrate.
  - LOCKED: owner holds the port.
- Arbitration (IDLE, or LOCKED after a release): the winner is the first asserted req scanning from rr_ptr upward, with modulo NUM_REQ wrap-around. gnt is one-hot for the winner; it is zero when req is zero.
- On a grant to requester w at clock edge:
  - rr_ptr <= (w+1) mod NUM_REQ.
  - If req_lock[w]=1: go to LOCKED, owner<=w, burst_cnt<=1.
  - Otherwise stay in/return to IDLE.
- LOCKED:
  - gnt[owner]=req[owner]; all other gnt are 0, even if owner deasserts req (the port idles, lock is held).
  - Each granted cycle increments burst_cnt.
  - Leave LOCKED to IDLE when: (a) owner presents req_lock=0 on a granted access (that access still completes), (b) burst_cnt reaches MAX_BURST (forced release after that access), or (c) owner has req=0 and req_lock=0.
  - A forced release puts rr_ptr past the owner, so another waiting requester wins next.
- SRAM drive (combinational from winner):
  - sram_write_enable = req_we[w].
  - sram_write_addresss = sram_read_address = req_addr[w].
  - sram_write_data = req_wdata[w].
  - With no grant: enable=0; addresses and data hold 0.
- Read return: a granted read (req_we=0) in cycle t sets rvalid[w]=1 in cycle t+1, for exactly one cycle. Back-to-back reads give back-to-back rvalid. A granted write produces no rvalid.
- Simultaneous events:
  - Reset dominates everything.
  - Reset mid-burst drops the lock and any pending rvalid.
  - Lock release and a new request in the same cycle: the new request waits one cycle (arbitration happens the following cycle from the updated rr_ptr).
- Width rules: no arithmetic on data. burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
- Assertions for the bench: gnt and rvalid are onehot0; gnt[i] implies req[i].

Decomposition:
- Shared package (sram_arb_pkg): the state enum (IDLE, LOCKED) and the default ADDR_W/DATA_W localparams used across the SRAM-facing blocks.
- One natural sub-module: rr_priority_pick, a combinational one-hot picker (req vector plus rotate pointer gives one-hot winner and encoded index). It is reused by other arbiters in the design.

Test Plan:
- Single read: req=3'b001, addr=12'h010, we=0 -> gnt=001 same cycle, sram_read_address=12'h010; next cycle rvalid=001 and rdata = SRAM word at 0x010.
- Round-robin fairness: req=3'b111 held 6 cycles, no lock -> grant order 0,1,2,0,1,2; rvalid follows one cycle later with the same order.
- Locked burst: requester 1 issues 5 reads with req_lock=1, dropping lock on the 5th, while req[0] and req[2] are held -> gnt=010 for 5 cycles, then requester 2 wins, then requester 0.
- Forced release: MAX_BURST=4, requester 0 holds lock and req for 10 cycles, req[1]=1 -> requester 0 granted 4 cycles, requester 1 granted on the 5th cycle, requester 0 resumes after.
- Write pass-through: requester 2 writes 16'hA5C3 to 12'h7FF -> sram_write_enable=1, sram_write_addresss=12'h7FF, sram_write_data=16'hA5C3 in the same cycle; rvalid stays 0.
- Reset mid-burst: assert reset asynchronously during a locked read burst -> gnt, rvalid and sram_write_enable go 0 immediately; after release, req=3'b100 is granted first-come from rr_ptr=0 scan (winner = requester 2).
